// File: rtl/pwd_pkg.sv
// Shared defaults, sizing helper and payload types for the pulse width detector.
package pwd_pkg;

    localparam int unsigned DEF_N_CH  = 4;
    localparam int unsigned DEF_MAX_W = 8;
    localparam int unsigned DEF_EV_W  = 8;

    // Run counter must hold 0..MAX_W plus one "too long" saturation value.
    function automatic int unsigned calc_cw(input int unsigned max_w);
        return $clog2(max_w + 2);
    endfunction

    localparam int unsigned DEF_CW = calc_cw(DEF_MAX_W);

    typedef logic [DEF_EV_W-1:0] ev_cnt_t;
    typedef logic [DEF_CW-1:0]   run_t;

endpackage

// File: rtl/pulse_width_channel.sv
// One detector channel: edge flags, run-length tracking and matched-pulse counter.
module pulse_width_channel
    import pwd_pkg::*;
#(
    parameter int unsigned MAX_W = DEF_MAX_W,
    parameter int unsigned CW    = calc_cw(MAX_W),
    parameter int unsigned EV_W  = DEF_EV_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_act,
    input  logic [CW-1:0]   width,
    input  logic            width_ok,
    input  logic            ev_clr,
    output logic            rise,
    output logic            fall,
    output logic            pulse,
    output logic [EV_W-1:0] ev
);

    localparam logic [CW-1:0]   RUN_SAT = CW'(MAX_W + 1);
    localparam logic [EV_W-1:0] EV_MAX  = '1;

    logic          act_r;
    logic [CW-1:0] run;

    // Input history and saturating run length of consecutive active cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_r <= 1'b0;
            run   <= '0;
        end else begin
            act_r <= a_act;
            if (!a_act) begin
                run <= '0;
            end else if (run != RUN_SAT) begin
                run <= run + CW'(1);
            end
        end
    end

    // Same-cycle flags from the live input against registered history.
    always_comb begin
        rise  = a_act & ~act_r;
        fall  = ~a_act & act_r;
        pulse = fall & width_ok & (run == width);
    end

    // Matched-pulse counter: clear has priority, saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ev <= '0;
        end else if (ev_clr) begin
            ev <= '0;
        end else if (pulse && (ev != EV_MAX)) begin
            ev <= ev + EV_W'(1);
        end
    end

endmodule

// File: rtl/multi_channel_pulse_width_detector.sv
// N_CH-channel edge and exact-width pulse detector with per-channel event counters.
module multi_channel_pulse_width_detector
    import pwd_pkg::*;
#(
    parameter int unsigned N_CH       = DEF_N_CH,
    parameter int unsigned MAX_W      = DEF_MAX_W,
    parameter int unsigned CW         = calc_cw(MAX_W),
    parameter int unsigned EV_W       = DEF_EV_W,
    parameter int unsigned ACTIVE_LOW = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      a,
    input  logic [CW-1:0]        width,
    input  logic                 ev_clr,
    output logic [N_CH-1:0]      rise,
    output logic [N_CH-1:0]      fall,
    output logic [N_CH-1:0]      pulse,
    output logic [N_CH*EV_W-1:0] ev_cnt
);

    localparam logic POL = (ACTIVE_LOW != 0);

    logic [N_CH-1:0] a_act;
    logic            width_ok;

    // Polarity normalisation and shared width-range decode.
    always_comb begin
        a_act    = a ^ {N_CH{POL}};
        width_ok = (width != '0) && (32'(width) <= MAX_W);
    end

    // Independent channel instances; counters packed with ch0 in the LSBs.
    for (genvar ch = 0; ch < int'(N_CH); ch++) begin : g_ch
        pulse_width_channel #(
            .MAX_W (MAX_W),
            .CW    (CW),
            .EV_W  (EV_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .a_act    (a_act[ch]),
            .width    (width),
            .width_ok (width_ok),
            .ev_clr   (ev_clr),
            .rise     (rise[ch]),
            .fall     (fall[ch]),
            .pulse    (pulse[ch]),
            .ev       (ev_cnt[ch*EV_W +: EV_W])
        );
    end

endmodule

// File: doc/multi_channel_pulse_width_detector.md
Name: multi_channel_pulse_width_detector

Overview:
- N_CH-channel successor of the single-bit posedge / one-cycle-pulse detectors.
- Per channel, every cycle, it flags:
  - rising edges;
  - falling edges;
  - isolated pulses of exactly a runtime-programmable width (1..MAX_W cycles);
  - a saturating count of matched pulses.
- Sits directly behind synchronised control/status inputs.
- Output timing matches the earlier detectors: detect flags are combinational on the current input and registered history, valid in the same cycle the terminating edge appears.

Parameters:
- N_CH, 4, number of independent input channels.
- MAX_W, 8, largest programmable pulse width in cycles (>=1).
- CW, $clog2(MAX_W+2), width of run-length counter and width port.
- EV_W, 8, width of per-channel matched-pulse event counter.
- ACTIVE_LOW, 0, 1 = a pulse is a run of 0s bounded by 1s; all internal logic uses a_act = a ^ {N_CH{ACTIVE_LOW}}.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  asynchronous, active-low reset; all state cleared while rst==0.
- a  input  N_CH  sampled channel inputs, one bit per channel.
- width  input  CW  target pulse width, shared by all channels; 0 or >MAX_W disables pulse matching.
- ev_clr  input  1  synchronous clear of all event counters.
- rise  output  N_CH  a_act & ~act_r, per channel.
- fall  output  N_CH  ~a_act & act_r, per channel.
- pulse  output  N_CH  fall & (run[ch]==width) & width_ok.
- ev_cnt  output  N_CH*EV_W  packed per-channel matched-pulse counters, ch0 in LSBs.

Behaviour:
- State per channel:
  - act_r (1b): previous a_act.
  - run (CW bits): consecutive active cycles up to and including the last sampled cycle, saturating at MAX_W+1 ("too long").
  - ev (EV_W bits).
- Reset (rst==0, async):
  - act_r=0, run=0, ev=0.
  - Consequently rise=a_act, fall=0, pulse=0 and ev_cnt=0 while reset is held.
  - After release, history is "inactive", so a pulse starting in the first cycle is a valid isolated pulse.
- run update per posedge:
  - a_act==1: run <= (run==MAX_W+1) ? run : run+1.
  - a_act==0: run <= 0.
- act_r <= a_act every posedge.
- width_ok = (width>=1) && (width<=MAX_W). width is compared live in the fall cycle; changing width mid-pulse is legal and uses the value present at the fall.
- pulse is a single-cycle flag, asserted in the cycle a_act drops after exactly width active cycles preceded by inactive. A run longer than MAX_W never matches.
- ev update per posedge, in priority order:
  1. ev_clr==1: ev <= 0. Clear wins over a simultaneous pulse, so that pulse is not counted.
  2. pulse[ch]==1 and ev != all-ones: ev <= ev+1.
  3. Otherwise hold; the counter saturates at all-ones and does not wrap.
- Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.
- Reset asserted mid-pulse: run clears, and the pulse in progress is never reported.
- No other latency: rise/fall/pulse are zero-cycle combinational; ev_cnt reflects a pulse one cycle after its flag.

Decomposition:
- Package pwd_pkg:
  - localparam functions for CW;
  - typedef ev_cnt_t (logic [EV_W-1:0]);
  - typedef run_t.
- Sub-module pulse_width_channel (one channel: act_r, run, ev, rise/fall/pulse), instantiated N_CH times in a generate loop.
- Top-level responsibilities: polarity XOR, width_ok decode, output packing.

Test Plan:
- Reset then ch0 a = 1001011011110001 (one bit per cycle), width=1 -> pulse[0] = 0100100000000000, rise[0] = 1001010010000001; ev_cnt[0] reads 2 after the sequence.
- Same sequence, width=2 -> pulse[0] = 0000000100000000; width=4 -> pulse[0] = 0000000000001000 (the 1111 run matches at its fall).
- MAX_W=8, 10-cycle high run then low, width=8 -> no pulse; width=0 with any sequence -> pulse never set, while rise/fall still toggle.
- ACTIVE_LOW=1, ch2 a = 1101111 with width=1 -> pulse[2] asserted in cycle 3 (index from 0), rise[2] asserted in cycle 2; other channels held at 1 stay silent.
- Generate 255+3 width-1 pulses on ch1 -> ev_cnt[1] saturates at 255. Then drive ev_clr in the same cycle as a pulse -> ev_cnt[1]=0 next cycle, not 1.
- Drop rst for 1 cycle mid-way through a 3-cycle pulse with width=3 -> no pulse reported; outputs match their reset values during reset; the next clean 3-cycle pulse is detected.
